// File: rtl/move_sequencer_if.sv
// Button/flag inputs and move-command outputs of the 2048 move front end.
// The master modport is the sequencer side; the slave modport is the board/datapath side.
interface move_sequencer_if #(
    parameter int QUEUE_DEPTH = 4
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic          btnL;
    logic          btnR;
    logic          btnU;
    logic          btnD;
    logic          won;
    logic          lost;
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic [CW-1:0] queue_count;
    logic          dropped;

    modport master (
        input  btnL, btnR, btnU, btnD, won, lost, move_ready,
        output move_valid, move_dir, queue_count, dropped
    );

    modport slave (
        output btnL, btnR, btnU, btnD, won, lost, move_ready,
        input  move_valid, move_dir, queue_count, dropped
    );
endinterface

// File: rtl/move_sequencer.sv
// 2048 move front end: per-button sync/debounce lanes, priority arbitration, move FIFO, RUN/BLOCK/REARM gate.
// Optional auto-repeat of a single held button is built when MOVE_REPEAT_EN is defined.
module move_sequencer_lane #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic toggle
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] cnt;

    // toggle is high in the last differing cycle; level flips at the following edge
    assign toggle = (s2 != level) && (cnt == DW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (toggle) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module move_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int QUEUE_DEPTH     = 4,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    move_sequencer_if.master  bus
);
    localparam int NUM_BTN = 4;
    localparam int PW      = $clog2(QUEUE_DEPTH);
    localparam int CW      = PW + 1;

    typedef enum logic [1:0] {RUN, BLOCK, REARM} state_t;

    state_t                       state;
    logic [NUM_BTN-1:0]           raw;
    logic [NUM_BTN-1:0]           level;
    logic [NUM_BTN-1:0]           toggle;
    logic [NUM_BTN-1:0]           press;
    logic [NUM_BTN-1:0]           rpt;
    logic [NUM_BTN-1:0]           events;
    logic [QUEUE_DEPTH-1:0][1:0]  mem;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [CW-1:0]                count;
    logic                         dropped_q;
    logic [1:0]                   sel_dir;
    logic                         multi;
    logic                         is_run;
    logic                         full;
    logic                         pop;
    logic                         push_req;
    logic                         push;
    logic                         drop_n;
    logic                         flush;

    assign raw = {bus.btnD, bus.btnU, bus.btnR, bus.btnL};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        move_sequencer_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw[i]),
            .level  (level[i]),
            .toggle (toggle[i])
        );
    end

    assign press  = toggle & ~level;
    assign is_run = (state == RUN);

`ifdef MOVE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_armed;
    logic          hold;
    logic [RW-1:0] rpt_limit;

    // any debounced change or leaving RUN restarts the delay from scratch
    assign hold      = is_run && $onehot(level) && !(|toggle);
    assign rpt_limit = rpt_armed ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    assign rpt       = (hold && rpt_cnt == rpt_limit) ? level : '0;

    always_ff @(posedge clk) begin
        if (rst || !hold) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_cnt == rpt_limit) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt = '0;
`endif

    assign events = press | rpt;

    always_comb begin
        sel_dir = 2'd0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (events[i]) sel_dir = 2'(i);
        end
    end

    assign multi    = |(events & (events - 4'd1));
    assign full     = (count == CW'(QUEUE_DEPTH));
    assign pop      = bus.move_valid && bus.move_ready;
    assign push_req = is_run && (|events);
    // a full queue still accepts when the head leaves in the same cycle
    assign push     = push_req && (!full || pop);
    assign drop_n   = is_run && (multi || (push_req && full && !pop));
    assign flush    = !is_run || bus.won || bus.lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            mem       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= drop_n;
            case (state)
                RUN:     if (bus.won || bus.lost) state <= BLOCK;
                BLOCK:   if (!bus.won && !bus.lost) state <= REARM;
                REARM: begin
                    if (bus.won || bus.lost) state <= BLOCK;
                    else if (level == '0)   state <= RUN;
                end
                default: state <= RUN;
            endcase
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= sel_dir;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (!push && pop) count <= count - 1'b1;
            end
        end
    end

    assign bus.move_valid  = is_run && (count != '0);
    assign bus.move_dir    = mem[rd_ptr];
    assign bus.queue_count = count;
    assign bus.dropped     = dropped_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Directed plus random checks of move_sequencer against a queue-based reference model.
module tb_move_sequencer;
    localparam int DB = 4;
    localparam int QD = 4;
    localparam int M_RUN = 0, M_BLOCK = 1, M_REARM = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    move_sequencer_if #(.QUEUE_DEPTH(QD)) bus();

    move_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .QUEUE_DEPTH    (QD),
        .REPEAT_DELAY   (40),
        .REPEAT_PERIOD  (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int ndrop  = 0;

    // reference model: screen state, synchronizer pipe, window of synced samples, move queue
    int         mst;
    logic [3:0] ms1, ms2, mlev;
    logic [3:0] hist[$];
    int         mq[$];
    logic       mdrop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mst = M_RUN; ms1 = '0; ms2 = '0; mlev = '0; mdrop = 1'b0;
        hist.delete();
        mq.delete();
    endtask

    task automatic model_edge(input logic [3:0] b, input logic w, input logic l, input logic r);
        logic [3:0] flip, ev;
        bit all_diff, mvalid, pop, full;
        int dir;
        // a level flips once the last DB synced samples all disagree with it
        hist.push_back(ms2);
        if (hist.size() > DB) void'(hist.pop_front());
        flip = '0;
        if (hist.size() == DB) begin
            for (int bi = 0; bi < 4; bi++) begin
                all_diff = 1;
                foreach (hist[k]) if (hist[k][bi] == mlev[bi]) all_diff = 0;
                flip[bi] = all_diff;
            end
        end
        ev     = flip & ~mlev;
        mvalid = (mst == M_RUN) && (mq.size() > 0);
        pop    = mvalid && r;
        full   = (mq.size() == QD);
        mdrop  = 1'b0;
        if (pop) void'(mq.pop_front());
        if (mst == M_RUN && ev != 0) begin
            dir = 0;
            for (int bi = 3; bi >= 0; bi--) if (ev[bi]) dir = bi;
            if (!full || pop) mq.push_back(dir);
            mdrop = ($countones(ev) > 1) || (full && !pop);
        end
        if (mst != M_RUN || w || l) mq.delete();
        case (mst)
            M_RUN:   if (w || l) mst = M_BLOCK;
            M_BLOCK: if (!w && !l) mst = M_REARM;
            default: if (w || l) mst = M_BLOCK; else if (mlev == 0) mst = M_RUN;
        endcase
        mlev = mlev ^ flip;
        ms2  = ms1;
        ms1  = b;
    endtask

    task automatic step(input logic [3:0] b, input logic w, input logic l, input logic r, input logic rs);
        bit ev_valid;
        bus.btnL = b[0]; bus.btnR = b[1]; bus.btnU = b[2]; bus.btnD = b[3];
        bus.won = w; bus.lost = l; bus.move_ready = r; rst = rs;
        @(posedge clk);
        if (rs) model_reset();
        else model_edge(b, w, l, r);
        #1;
        ev_valid = (mst == M_RUN) && (mq.size() > 0);
        chk("move_valid", 32'(bus.move_valid), 32'(ev_valid));
        chk("queue_count", 32'(bus.queue_count), 32'(mq.size()));
        chk("dropped", 32'(bus.dropped), 32'(mdrop));
        if (ev_valid) chk("move_dir", 32'(bus.move_dir), 32'(mq[0]));
        if (bus.move_valid) nvalid++;
        if (bus.dropped) ndrop++;
    endtask

    task automatic press(input int bi, input logic r);
        logic [3:0] b;
        b = '0;
        b[bi] = 1'b1;
        for (int k = 0; k < 7; k++) step(b, 0, 0, r, 0);
        for (int k = 0; k < 6; k++) step('0, 0, 0, r, 0);
    endtask

    initial begin
        int first_k;
        logic [3:0] b;
        logic w, l, rs;
        model_reset();
        step('0, 0, 0, 0, 1);
        step('0, 0, 0, 0, 1);
        chk("reset_count", 32'(bus.queue_count), 32'd0);
        chk("reset_valid", 32'(bus.move_valid), 32'd0);
        chk("reset_dir", 32'(bus.move_dir), 32'd0);
        chk("reset_dropped", 32'(bus.dropped), 32'd0);

        // single held R press: one move, visible right after edge 2+DB
        nvalid = 0; first_k = -1;
        for (int k = 1; k <= 20; k++) begin
            step(4'b0010, 0, 0, 1, 0);
            if (bus.move_valid) begin
                if (first_k < 0) first_k = k;
                chk("t1_dir", 32'(bus.move_dir), 32'd1);
            end
        end
        chk("t1_first", 32'(first_k), 32'd6);
        chk("t1_moves", 32'(nvalid), 32'd1);
        for (int k = 0; k < 8; k++) step('0, 0, 0, 1, 0);

        // bounce shorter than the debounce window
        nvalid = 0; ndrop = 0;
        for (int k = 0; k < 12; k++) step(((k >> 1) & 1) ? 4'b0001 : 4'b0000, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) step('0, 0, 0, 1, 0);
        chk("t2_moves", 32'(nvalid), 32'd0);
        chk("t2_drops", 32'(ndrop), 32'd0);

        // U and D together: U wins, D dropped once
        ndrop = 0;
        for (int k = 0; k < 10; k++) step(4'b1100, 0, 0, 0, 0);
        chk("t3_count", 32'(bus.queue_count), 32'd1);
        chk("t3_dir", 32'(bus.move_dir), 32'd2);
        chk("t3_drops", 32'(ndrop), 32'd1);
        for (int k = 0; k < 8; k++) step('0, 0, 0, 0, 0);
        step('0, 0, 0, 1, 0);
        chk("t3_drained", 32'(bus.queue_count), 32'd0);

        // fill past capacity, then drain at one move per cycle
        ndrop = 0;
        press(0, 0); press(1, 0); press(2, 0); press(3, 0); press(0, 0);
        chk("t4_count", 32'(bus.queue_count), 32'd4);
        chk("t4_drops", 32'(ndrop), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t4_dir", 32'(bus.move_dir), 32'(k));
            chk("t4_valid", 32'(bus.move_valid), 32'd1);
            step('0, 0, 0, 1, 0);
        end
        chk("t4_empty", 32'(bus.queue_count), 32'd0);

        // game over flushes; a button held across the screen never moves
        press(0, 0); press(1, 0);
        chk("t5_count", 32'(bus.queue_count), 32'd2);
        step('0, 1, 0, 0, 0);
        chk("t5_blk_valid", 32'(bus.move_valid), 32'd0);
        chk("t5_blk_count", 32'(bus.queue_count), 32'd0);
        for (int k = 0; k < 8; k++) step(4'b1000, 1, 0, 0, 0);
        nvalid = 0;
        for (int k = 0; k < 12; k++) step(4'b1000, 0, 0, 1, 0);
        chk("t5_held_moves", 32'(nvalid), 32'd0);
        for (int k = 0; k < 8; k++) step('0, 0, 0, 1, 0);
        nvalid = 0; first_k = -1;
        for (int k = 0; k < 7; k++) begin
            step(4'b0001, 0, 0, 1, 0);
            if (bus.move_valid && first_k < 0) begin
                first_k = k;
                chk("t5_dir", 32'(bus.move_dir), 32'd0);
            end
        end
        chk("t5_moves", 32'(nvalid), 32'd1);
        for (int k = 0; k < 6; k++) step('0, 0, 0, 1, 0);

        // reset mid-operation
        press(0, 0); press(1, 0); press(2, 0);
        chk("t6_valid", 32'(bus.move_valid), 32'd1);
        chk("t6_count", 32'(bus.queue_count), 32'd3);
        step('0, 0, 0, 0, 1);
        chk("t6_rst_count", 32'(bus.queue_count), 32'd0);
        chk("t6_rst_valid", 32'(bus.move_valid), 32'd0);
        chk("t6_rst_dir", 32'(bus.move_dir), 32'd0);
        chk("t6_rst_dropped", 32'(bus.dropped), 32'd0);

        // random traffic against the model
        b = '0; w = 0; l = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int bi = 0; bi < 4; bi++) if ($urandom_range(9) == 0) b[bi] = ~b[bi];
            if (!w && $urandom_range(149) == 0) w = 1; else if (w && $urandom_range(11) == 0) w = 0;
            if (!l && $urandom_range(199) == 0) l = 1; else if (l && $urandom_range(11) == 0) l = 0;
            rs = ($urandom_range(699) == 0);
            step(b, w, l, 1'($urandom_range(1)), rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
